// File: rtl/mem_stage_lsu.sv
// Load/store unit for the MEM stage. Sequences one load/store per handshake
// against a word-wide data memory with combinational read data. Byte stores
// use a read-modify-write: the word is read, the byte is merged, then written.
// Memory layout is big-endian: the even byte sits in [15:8], the odd byte in [7:0].
module mem_stage_lsu #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int MEM_BYTES = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [1:0]        i_req_op,
    input  logic              i_req_sext,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    input  logic [2:0]        i_req_rd,
    output logic              o_mem_write_enable,
    output logic              o_mem_read_enable,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [DATA_W-1:0] o_mem_data_out,
    input  logic [DATA_W-1:0] i_mem_data_in,
    output logic              o_wb_valid,
    output logic              o_wb_we,
    output logic [DATA_W-1:0] o_wb_data,
    output logic [2:0]        o_wb_rd,
    output logic              o_fault,
    output logic [ADDR_W-1:0] o_fault_addr
);

    typedef enum logic [1:0] {
        OP_LW = 2'b00,
        OP_SW = 2'b01,
        OP_LB = 2'b10,
        OP_SB = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RMW_WR,
        S_FAULT
    } state_t;

    localparam logic [ADDR_W-1:0] MAX_WB = ADDR_W'(MEM_BYTES - 2);

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic              sext_q, sext_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        rd_q, rd_d;
    logic [DATA_W-1:0] merged_q, merged_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_we_q, wb_we_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [2:0]        wb_rd_q, wb_rd_d;
    logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;

    logic [ADDR_W-1:0] req_wb;
    logic              req_illegal;
    logic [7:0]        sel_byte;
    logic [DATA_W-1:0] lb_result;
    logic [DATA_W-1:0] merge_word;

    // Request decode: word base and legality check at accept time
    always_comb begin
        req_wb      = {i_req_addr[ADDR_W-1:1], 1'b0};
        req_illegal = (((op_t'(i_req_op) == OP_LW) || (op_t'(i_req_op) == OP_SW)) && i_req_addr[0])
                      || (req_wb > MAX_WB);
    end

    // Byte lane select, load extension and byte-store merge from memory read data
    always_comb begin
        sel_byte   = addr_q[0] ? i_mem_data_in[7:0] : i_mem_data_in[DATA_W-1:DATA_W-8];
        lb_result  = {{(DATA_W-8){sext_q & sel_byte[7]}}, sel_byte};
        merge_word = addr_q[0] ? {i_mem_data_in[DATA_W-1:8], wdata_q[7:0]}
                               : {wdata_q[7:0], i_mem_data_in[DATA_W-9:0]};
    end

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            op_q         <= OP_LW;
            sext_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= '0;
            merged_q     <= '0;
            mem_addr_q   <= '0;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_data_q    <= '0;
            wb_rd_q      <= '0;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            sext_q       <= sext_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            merged_q     <= merged_d;
            mem_addr_q   <= mem_addr_d;
            wb_valid_q   <= wb_valid_d;
            wb_we_q      <= wb_we_d;
            wb_data_q    <= wb_data_d;
            wb_rd_q      <= wb_rd_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    // Next-state and register updates for the access sequence
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        sext_d       = sext_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        merged_d     = merged_q;
        mem_addr_d   = mem_addr_q;
        wb_valid_d   = 1'b0;
        wb_we_d      = wb_we_q;
        wb_data_d    = wb_data_q;
        wb_rd_d      = wb_rd_q;
        fault_addr_d = fault_addr_q;

        unique case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    op_d    = op_t'(i_req_op);
                    sext_d  = i_req_sext;
                    addr_d  = i_req_addr;
                    wdata_d = i_req_wdata;
                    rd_d    = i_req_rd;
                    if (req_illegal) begin
                        state_d      = S_FAULT;
                        fault_addr_d = i_req_addr;
                    end else begin
                        // memory address only moves for accesses that actually happen
                        state_d    = S_ACCESS;
                        mem_addr_d = req_wb;
                    end
                end
            end
            S_ACCESS: begin
                unique case (op_q)
                    OP_LW, OP_LB: begin
                        state_d    = S_IDLE;
                        wb_valid_d = 1'b1;
                        wb_we_d    = 1'b1;
                        wb_data_d  = (op_q == OP_LW) ? i_mem_data_in : lb_result;
                        wb_rd_d    = rd_q;
                    end
                    OP_SW: begin
                        state_d    = S_IDLE;
                        wb_valid_d = 1'b1;
                        wb_we_d    = 1'b0;
                        wb_data_d  = '0;
                        wb_rd_d    = rd_q;
                    end
                    OP_SB: begin
                        state_d  = S_RMW_WR;
                        merged_d = merge_word;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            S_RMW_WR: begin
                state_d    = S_IDLE;
                wb_valid_d = 1'b1;
                wb_we_d    = 1'b0;
                wb_data_d  = '0;
                wb_rd_d    = rd_q;
            end
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Memory strobes decoded from state so reset removes them immediately
    always_comb begin
        o_mem_read_enable  = (state_q == S_ACCESS) && (op_q != OP_SW);
        o_mem_write_enable = ((state_q == S_ACCESS) && (op_q == OP_SW)) || (state_q == S_RMW_WR);
        o_mem_data_out     = '0;
        if ((state_q == S_ACCESS) && (op_q == OP_SW)) begin
            o_mem_data_out = wdata_q;
        end else if (state_q == S_RMW_WR) begin
            o_mem_data_out = merged_q;
        end
        o_mem_address = mem_addr_q;
        o_req_ready   = (state_q == S_IDLE);
        o_fault       = (state_q == S_FAULT);
        o_fault_addr  = fault_addr_q;
        o_wb_valid    = wb_valid_q;
        o_wb_we       = wb_we_q;
        o_wb_data     = wb_data_q;
        o_wb_rd       = wb_rd_q;
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Testbench for mem_stage_lsu: a 16-byte big-endian memory model hangs off the
// LSU, and a separate byte-array reference computes expected results.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic        req_sext;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [2:0]  req_rd;
    logic        mem_we, mem_re;
    logic [15:0] mem_addr, mem_dout, mem_din;
    logic        wb_valid, wb_we;
    logic [15:0] wb_data;
    logic [2:0]  wb_rd;
    logic        fault;
    logic [15:0] fault_addr;

    logic [7:0] dev_mem [0:15];
    logic [7:0] ref_mem [0:15];

    int n_vec = 0;
    int n_err = 0;

    // observations from the most recent transaction
    int          obs_lat, obs_wbv_cnt, obs_fault_cnt, obs_rd_cyc, obs_wr_cyc;
    logic        obs_both, obs_wb_we, obs_ready_start, obs_ready_end;
    logic [15:0] obs_wb_data, obs_fault_addr, obs_wr_addr, obs_wr_data;
    logic [2:0]  obs_wb_rd;

    always #5 clk = ~clk;

    mem_stage_lsu #(.DATA_W(16), .ADDR_W(16), .MEM_BYTES(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_op(req_op), .i_req_sext(req_sext), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .i_req_rd(req_rd),
        .o_mem_write_enable(mem_we), .o_mem_read_enable(mem_re),
        .o_mem_address(mem_addr), .o_mem_data_out(mem_dout), .i_mem_data_in(mem_din),
        .o_wb_valid(wb_valid), .o_wb_we(wb_we), .o_wb_data(wb_data), .o_wb_rd(wb_rd),
        .o_fault(fault), .o_fault_addr(fault_addr)
    );

    // data memory: combinational read, write on the falling edge
    assign mem_din = {dev_mem[{mem_addr[3:1], 1'b0}], dev_mem[{mem_addr[3:1], 1'b1}]};
    always @(negedge clk) begin
        if (mem_we) begin
            dev_mem[{mem_addr[3:1], 1'b0}] = mem_dout[15:8];
            dev_mem[{mem_addr[3:1], 1'b1}] = mem_dout[7:0];
        end
    end

    task automatic preload(input int a, input logic [7:0] b);
        dev_mem[a] = b;
        ref_mem[a] = b;
    endtask

    // drive one request, then watch four cycles after the accept edge
    task automatic issue(input logic [1:0] op, input logic sext, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [2:0] rd);
        @(negedge clk);
        obs_ready_start = req_ready;
        req_op = op; req_sext = sext; req_addr = addr; req_wdata = wdata; req_rd = rd;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        obs_lat = 0; obs_wbv_cnt = 0; obs_fault_cnt = 0; obs_rd_cyc = 0; obs_wr_cyc = 0;
        obs_both = 1'b0; obs_wb_we = 1'b0; obs_wb_data = '0; obs_wb_rd = '0;
        obs_fault_addr = '0; obs_wr_addr = '0; obs_wr_data = '0;
        for (int k = 1; k <= 4; k++) begin
            if (wb_valid) begin
                obs_wbv_cnt++;
                if (obs_lat == 0) begin
                    obs_lat = k; obs_wb_we = wb_we; obs_wb_data = wb_data; obs_wb_rd = wb_rd;
                end
            end
            if (fault) begin obs_fault_cnt++; obs_fault_addr = fault_addr; end
            if (mem_re) obs_rd_cyc++;
            if (mem_we) begin obs_wr_cyc++; obs_wr_addr = mem_addr; obs_wr_data = mem_dout; end
            if (mem_re && mem_we) obs_both = 1'b1;
            if (k < 4) begin @(posedge clk); #1; end
        end
        obs_ready_end = req_ready;
    endtask

    // reference: architectural effect of one op on a byte array
    task automatic ref_op(input logic [1:0] op, input logic sext, input logic [15:0] addr,
                          input logic [15:0] wdata, output logic flt, output int lat,
                          output logic we, output logic [15:0] data,
                          output int nrd, output int nwr);
        logic [15:0] wbase;
        logic [7:0]  b;
        wbase = addr & 16'hFFFE;
        flt = ((op == 2'b00 || op == 2'b01) && addr[0]) || (wbase > 16'd14);
        lat = 0; we = 1'b0; data = '0; nrd = 0; nwr = 0;
        if (!flt) begin
            case (op)
                2'b00: begin
                    lat = 2; we = 1'b1; nrd = 1;
                    data = {ref_mem[int'(wbase)], ref_mem[int'(wbase) + 1]};
                end
                2'b01: begin
                    lat = 2; nwr = 1;
                    ref_mem[int'(wbase)] = wdata[15:8];
                    ref_mem[int'(wbase) + 1] = wdata[7:0];
                end
                2'b10: begin
                    lat = 2; we = 1'b1; nrd = 1;
                    b = ref_mem[int'(addr)];
                    data = sext ? {{8{b[7]}}, b} : {8'h00, b};
                end
                default: begin
                    lat = 3; nrd = 1; nwr = 1;
                    ref_mem[int'(addr)] = wdata[7:0];
                end
            endcase
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        n_vec++;
        if ({mem_we, mem_re, wb_valid, wb_we, fault} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags: got %b expected 00000", {mem_we, mem_re, wb_valid, wb_we, fault});
        end
        n_vec++;
        if ({mem_addr, mem_dout, wb_data, fault_addr, 1'b0, wb_rd} !== 68'h0) begin
            n_err++; $display("FAIL reset_buses: got %h/%h/%h/%h/%h expected all 0",
                              mem_addr, mem_dout, wb_data, fault_addr, wb_rd);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word_ops;
        preload(4, 8'hBE); preload(5, 8'hEF);
        issue(2'b00, 1'b0, 16'd4, 16'h0, 3'd3);
        n_vec++; if (obs_ready_start !== 1'b1) begin n_err++; $display("FAIL lw_ready: got %b expected 1", obs_ready_start); end
        n_vec++; if (obs_rd_cyc != 1 || obs_wr_cyc != 0) begin n_err++; $display("FAIL lw_enables: got rd=%0d wr=%0d expected rd=1 wr=0", obs_rd_cyc, obs_wr_cyc); end
        n_vec++; if (obs_lat != 2) begin n_err++; $display("FAIL lw_latency: got %0d expected 2", obs_lat); end
        n_vec++;
        if ({obs_wb_we, obs_wb_data, obs_wb_rd} !== {1'b1, 16'hBEEF, 3'd3}) begin
            n_err++; $display("FAIL lw_result: got we=%b data=%h rd=%0d expected we=1 data=beef rd=3", obs_wb_we, obs_wb_data, obs_wb_rd);
        end
        issue(2'b01, 1'b0, 16'd6, 16'h1234, 3'd5);
        ref_mem[6] = 8'h12; ref_mem[7] = 8'h34;
        n_vec++;
        if (obs_wr_cyc != 1 || obs_rd_cyc != 0 || obs_wr_addr !== 16'd6 || obs_wr_data !== 16'h1234) begin
            n_err++; $display("FAIL sw_write: got wr=%0d rd=%0d addr=%h data=%h expected 1 0 0006 1234", obs_wr_cyc, obs_rd_cyc, obs_wr_addr, obs_wr_data);
        end
        n_vec++;
        if (obs_lat != 2 || obs_wb_we !== 1'b0 || obs_wb_data !== 16'h0 || obs_wb_rd !== 3'd5) begin
            n_err++; $display("FAIL sw_complete: got lat=%0d we=%b data=%h rd=%0d expected 2 0 0000 5", obs_lat, obs_wb_we, obs_wb_data, obs_wb_rd);
        end
        issue(2'b00, 1'b0, 16'd6, 16'h0, 3'd1);
        n_vec++; if (obs_wb_data !== 16'h1234) begin n_err++; $display("FAIL sw_readback: got %h expected 1234", obs_wb_data); end
    endtask

    task automatic test_byte_store;
        preload(8, 8'hAA); preload(9, 8'hBB);
        issue(2'b11, 1'b0, 16'd9, 16'h775C, 3'd2);
        ref_mem[9] = 8'h5C;
        n_vec++;
        if (obs_rd_cyc != 1 || obs_wr_cyc != 1 || obs_both !== 1'b0 || obs_wr_data !== 16'hAA5C || obs_wr_addr !== 16'd8) begin
            n_err++; $display("FAIL sb_rmw: got rd=%0d wr=%0d both=%b data=%h addr=%h expected 1 1 0 aa5c 0008",
                              obs_rd_cyc, obs_wr_cyc, obs_both, obs_wr_data, obs_wr_addr);
        end
        n_vec++;
        if (obs_lat != 3 || obs_wb_we !== 1'b0 || obs_wb_rd !== 3'd2 || obs_wbv_cnt != 1) begin
            n_err++; $display("FAIL sb_complete: got lat=%0d we=%b rd=%0d pulses=%0d expected 3 0 2 1", obs_lat, obs_wb_we, obs_wb_rd, obs_wbv_cnt);
        end
        issue(2'b00, 1'b0, 16'd8, 16'h0, 3'd4);
        n_vec++; if (obs_wb_data !== 16'hAA5C) begin n_err++; $display("FAIL sb_readback: got %h expected aa5c", obs_wb_data); end
    endtask

    task automatic test_byte_load;
        preload(8, 8'h80); preload(9, 8'hFF);
        issue(2'b10, 1'b1, 16'd8, 16'h0, 3'd6);
        n_vec++; if (obs_wb_data !== 16'hFF80 || obs_lat != 2) begin n_err++; $display("FAIL lb_even_sext: got %h lat %0d expected ff80 lat 2", obs_wb_data, obs_lat); end
        issue(2'b10, 1'b0, 16'd8, 16'h0, 3'd6);
        n_vec++; if (obs_wb_data !== 16'h0080) begin n_err++; $display("FAIL lb_even_zext: got %h expected 0080", obs_wb_data); end
        issue(2'b10, 1'b1, 16'd9, 16'h0, 3'd7);
        n_vec++; if (obs_wb_data !== 16'hFFFF || obs_wb_rd !== 3'd7) begin n_err++; $display("FAIL lb_odd_sext: got %h rd %0d expected ffff rd 7", obs_wb_data, obs_wb_rd); end
        preload(15, 8'h41);
        issue(2'b10, 1'b1, 16'd15, 16'h0, 3'd1);
        n_vec++; if (obs_fault_cnt != 0 || obs_wb_data !== 16'h0041) begin n_err++; $display("FAIL lb_top_byte: got fault=%0d data=%h expected 0 0041", obs_fault_cnt, obs_wb_data); end
    endtask

    task automatic test_fault;
        issue(2'b01, 1'b0, 16'd3, 16'hDEAD, 3'd1);
        n_vec++;
        if (obs_fault_cnt != 1 || obs_fault_addr !== 16'd3 || obs_rd_cyc != 0 || obs_wr_cyc != 0 || obs_wbv_cnt != 0) begin
            n_err++; $display("FAIL fault_sw3: got faults=%0d addr=%h rd=%0d wr=%0d wbv=%0d expected 1 0003 0 0 0",
                              obs_fault_cnt, obs_fault_addr, obs_rd_cyc, obs_wr_cyc, obs_wbv_cnt);
        end
        issue(2'b00, 1'b0, 16'd15, 16'h0, 3'd1);
        n_vec++;
        if (obs_fault_cnt != 1 || obs_fault_addr !== 16'd15 || obs_rd_cyc != 0 || obs_wbv_cnt != 0 || obs_ready_end !== 1'b1) begin
            n_err++; $display("FAIL fault_lw15: got faults=%0d addr=%h rd=%0d wbv=%0d ready=%b expected 1 000f 0 0 1",
                              obs_fault_cnt, obs_fault_addr, obs_rd_cyc, obs_wbv_cnt, obs_ready_end);
        end
        issue(2'b10, 1'b0, 16'd16, 16'h0, 3'd1);
        n_vec++; if (obs_fault_cnt != 1 || obs_fault_addr !== 16'd16) begin n_err++; $display("FAIL fault_lb16: got faults=%0d addr=%h expected 1 0010", obs_fault_cnt, obs_fault_addr); end
        issue(2'b00, 1'b0, 16'd4, 16'h0, 3'd1);
        n_vec++; if (fault_addr !== 16'd16 || obs_fault_cnt != 0) begin n_err++; $display("FAIL fault_addr_hold: got %h faults=%0d expected 0010 0", fault_addr, obs_fault_cnt); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] e1, e2;
        e1 = {ref_mem[4], ref_mem[5]};
        e2 = {ref_mem[6], ref_mem[7]};
        @(negedge clk);
        req_op = 2'b00; req_addr = 16'd4; req_rd = 3'd1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_addr = 16'd6; req_rd = 3'd2;
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_busy: got ready %b expected 0", req_ready); end
        @(posedge clk); #1;
        n_vec++;
        if (wb_valid !== 1'b1 || wb_data !== e1 || wb_rd !== 3'd1 || req_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_first: got v=%b data=%h rd=%0d ready=%b expected 1 %h 1 1", wb_valid, wb_data, wb_rd, req_ready, e1);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_vec++; if (mem_re !== 1'b1 || mem_addr !== 16'd6) begin n_err++; $display("FAIL b2b_second_accept: got re=%b addr=%h expected 1 0006", mem_re, mem_addr); end
        @(posedge clk); #1;
        n_vec++; if (wb_valid !== 1'b1 || wb_data !== e2 || wb_rd !== 3'd2) begin n_err++; $display("FAIL b2b_second: got v=%b data=%h rd=%0d expected 1 %h 2", wb_valid, wb_data, wb_rd, e2); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid_rmw;
        int wbv;
        preload(8, 8'hAA); preload(9, 8'hBB);
        @(negedge clk);
        req_op = 2'b11; req_addr = 16'd9; req_wdata = 16'h005C; req_rd = 3'd5; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL rmw_reach_write: got we=%b expected 1", mem_we); end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (mem_we !== 1'b0 || req_ready !== 1'b1 || wb_valid !== 1'b0) begin
            n_err++; $display("FAIL rmw_reset_now: got we=%b ready=%b wbv=%b expected 0 1 0", mem_we, req_ready, wb_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wbv = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (wb_valid) wbv++;
        end
        n_vec++; if (wbv != 0) begin n_err++; $display("FAIL rmw_abort_wbv: got %0d pulses expected 0", wbv); end
        issue(2'b00, 1'b0, 16'd8, 16'h0, 3'd0);
        n_vec++; if (obs_wb_data !== 16'hAABB) begin n_err++; $display("FAIL rmw_abort_mem: got %h expected aabb", obs_wb_data); end
    endtask

    task automatic test_random;
        logic [1:0]  op;
        logic        sext, e_flt, e_we;
        logic [15:0] addr, wdata, e_data;
        logic [2:0]  rd;
        int          e_lat, e_nrd, e_nwr;
        for (int i = 0; i < 16; i++) preload(i, 8'($urandom));
        for (int n = 0; n < 150; n++) begin
            op    = 2'($urandom);
            sext  = 1'($urandom);
            addr  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 17));
            wdata = 16'($urandom);
            rd    = 3'($urandom);
            ref_op(op, sext, addr, wdata, e_flt, e_lat, e_we, e_data, e_nrd, e_nwr);
            issue(op, sext, addr, wdata, rd);
            n_vec++;
            if (obs_fault_cnt != int'(e_flt) || (e_flt && obs_fault_addr !== addr)) begin
                n_err++; $display("FAIL rnd_fault op=%0d addr=%h: got %0d/%h expected %0d/%h", op, addr, obs_fault_cnt, obs_fault_addr, e_flt, addr);
            end
            n_vec++;
            if (obs_lat != e_lat || obs_wbv_cnt != (e_flt ? 0 : 1)) begin
                n_err++; $display("FAIL rnd_latency op=%0d addr=%h: got %0d pulses %0d expected %0d", op, addr, obs_lat, obs_wbv_cnt, e_lat);
            end
            n_vec++;
            if (obs_rd_cyc != e_nrd || obs_wr_cyc != e_nwr || obs_both !== 1'b0) begin
                n_err++; $display("FAIL rnd_enables op=%0d addr=%h: got rd=%0d wr=%0d both=%b expected %0d %0d 0", op, addr, obs_rd_cyc, obs_wr_cyc, obs_both, e_nrd, e_nwr);
            end
            if (!e_flt) begin
                n_vec++;
                if (obs_wb_we !== e_we || obs_wb_data !== e_data || obs_wb_rd !== rd) begin
                    n_err++; $display("FAIL rnd_result op=%0d addr=%h: got we=%b data=%h rd=%0d expected %b %h %0d", op, addr, obs_wb_we, obs_wb_data, obs_wb_rd, e_we, e_data, rd);
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (dev_mem[i] !== ref_mem[i]) begin n_err++; $display("FAIL rnd_memory[%0d]: got %h expected %h", i, dev_mem[i], ref_mem[i]); end
        end
    endtask

    initial begin
        req_valid = 1'b0; req_op = '0; req_sext = 1'b0; req_addr = '0; req_wdata = '0; req_rd = '0;
        for (int i = 0; i < 16; i++) preload(i, 8'h00);
        test_reset;
        test_word_ops;
        test_byte_store;
        test_byte_load;
        test_fault;
        test_back_to_back;
        test_reset_mid_rmw;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
